// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared widths, types and copier state encoding
package mem_pkg;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 1 << ADDR_W;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [DATA_W-1:0] data_t;
    typedef logic [ADDR_W:0]   len_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        FIN
    } copier_state_e;

endpackage

// File: rtl/mem_block_copier.sv
// rtl/mem_block_copier.sv - block copy engine for a 1-cycle-latency synchronous memory
module mem_block_copier
    import mem_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  start,
    input  addr_t src_base,
    input  addr_t dst_base,
    input  len_t  length,
    output logic  busy,
    output logic  done,
    output logic  err,
    output data_t checksum,
    output addr_t mem_read_address,
    input  data_t mem_read_data,
    output addr_t mem_write_address,
    output logic  mem_write_en,
    output data_t mem_write_data
);

    copier_state_e state_q, state_d;
    addr_t         src_q, src_d;
    addr_t         dst_q, dst_d;
    len_t          len_q, len_d;
    len_t          k_q, k_d;
    logic          err_q, err_d;
    data_t         csum_q, csum_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            len_q   <= '0;
            k_q     <= '0;
            err_q   <= 1'b0;
            csum_q  <= '0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            len_q   <= len_d;
            k_q     <= k_d;
            err_q   <= err_d;
            csum_q  <= csum_d;
        end
    end

    always_comb begin
        state_d           = state_q;
        src_d             = src_q;
        dst_d             = dst_q;
        len_d             = len_q;
        k_d               = k_q;
        err_d             = err_q;
        csum_d            = csum_q;
        mem_read_address  = '0;
        mem_write_address = '0;
        mem_write_en      = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    src_d  = src_base;
                    dst_d  = dst_base;
                    len_d  = length;
                    k_d    = '0;
                    csum_d = '0;
                    err_d  = (length > len_t'(DEPTH));
                    if (length == '0 || length > len_t'(DEPTH)) begin
                        state_d = FIN;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                mem_read_address = src_q + addr_t'(k_q);
                mem_write_en     = (k_q != '0);
                k_d              = k_q + len_t'(1);
                if (k_q == len_q - len_t'(1)) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                mem_write_en = 1'b1;
                state_d      = FIN;
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Writes trail reads by one cycle; in DRAIN k_q == len_q, so the same formula hits the last word.
        if (mem_write_en) begin
            mem_write_address = dst_q + addr_t'(k_q - len_t'(1));
            csum_d            = csum_q ^ mem_read_data;
        end
    end

    assign mem_write_data = mem_read_data;
    assign busy           = (state_q == RUN) || (state_q == DRAIN);
    assign done           = (state_q == FIN);
    assign err            = (state_q == FIN) && err_q;
    assign checksum       = csum_q;

endmodule
